// File: rtl/riscvibe_pkg.sv
// -----------------------------------------------------------------------------
// riscvibe_pkg
// Shared types and constants for the RISC-Vibe pipeline front end.
//   if_id_reg_t     : IF/ID pipeline register contents
//   fetch_entry_t   : one prefetch FIFO entry {instruction, pc}
//   NOP_INSTRUCTION : addi x0, x0, 0 (bubble filler)
//   word_align()    : clear the byte offset of a fetch address
// -----------------------------------------------------------------------------
package riscvibe_pkg;

    localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] pc;
        logic [31:0] pc_plus_4;
        logic        valid;
    } if_id_reg_t;

    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] pc;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Synchronous FIFO, parametrised on entry type and depth (power of 2, >= 2).
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   clear              : drop all entries; wins over push and pop
//   push, push_data    : write an entry (accepted when not full, or when a pop
//                        frees a slot in the same cycle)
//   pop                : discard the head entry (ignored when empty)
//   head               : current head entry (undefined content when empty)
//   count, full, empty : occupancy
// -----------------------------------------------------------------------------
module fetch_fifo #(
    parameter type     entry_t = logic [63:0],
    parameter int      DEPTH   = 4,
    localparam int     AW      = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        push,
    input  entry_t      push_data,
    input  logic        pop,
    output entry_t      head,
    output logic [AW:0] count,
    output logic        full,
    output logic        empty
);

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    entry_t      mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count   = wr_ptr - rd_ptr;
    assign full    = (count == FULL_CNT);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW + 1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW + 1)'(1);
        end
    end

    // Storage needs no reset: nothing is read before it is written.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/if_prefetch_unit.sv
// -----------------------------------------------------------------------------
// if_prefetch_unit
// Decoupled instruction-fetch front end. Issues word fetches to a
// variable-latency instruction memory (valid/ready request, in-order
// always-accepted response), buffers returned words in a prefetch FIFO and
// presents the head to the IF/ID register. An EX redirect flushes the FIFO and
// marks all in-flight requests for discard.
//
// Parameters: FIFO_DEPTH (pow2 >= 2), MAX_OUTSTANDING (1..FIFO_DEPTH), RESET_PC
// Ports:
//   clk, rst_n                         : clock, async active-low reset
//   redirect_valid, redirect_pc        : taken branch/jump from EX
//   imem_req_valid/ready/addr          : fetch request channel
//   imem_rsp_valid, imem_rsp_data      : fetch response channel
//   out_ready                          : IF/ID can accept
//   if_id_out                          : instruction, pc, pc_plus_4, valid
//   perf_fetch_cnt, perf_discard_cnt   : only when RISCVIBE_FETCH_PERF_EN
// Optional feature macro: RISCVIBE_FETCH_PERF_EN (performance counters).
// -----------------------------------------------------------------------------
module if_prefetch_unit
    import riscvibe_pkg::*;
#(
    parameter int          FIFO_DEPTH      = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        out_ready,
`ifdef RISCVIBE_FETCH_PERF_EN
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_discard_cnt,
`endif
    output if_id_reg_t  if_id_out
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic         run;
    logic [31:0]  fetch_pc;
    logic [31:0]  rsp_pc;
    logic [31:0]  target;
    logic [OW-1:0] outstanding;
    logic [OW-1:0] outstanding_nxt;
    logic [OW-1:0] discard;

    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_push;
    logic          fifo_pop;
    fetch_entry_t  fifo_head;
    fetch_entry_t  push_entry;

    logic          req_hs;
    logic          out_valid;
    logic [31:0]   out_pc;

    assign target = word_align(redirect_pc);

    // run holds the request channel quiet while rst_n is low; it rises on the
    // first edge after release.
    // Credit check: every accepted request owns a FIFO slot, so a response can
    // always be pushed without overflow.
    assign imem_req_valid = run
                         && (32'(outstanding) < 32'(MAX_OUTSTANDING))
                         && (32'(outstanding) + 32'(fifo_count) < 32'(FIFO_DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign req_hs         = imem_req_valid && imem_req_ready;

    assign outstanding_nxt = outstanding + OW'(req_hs) - OW'(imem_rsp_valid);

    // Responses are kept only when no stale requests remain and no redirect is
    // killing this cycle's arrivals.
    assign fifo_push  = imem_rsp_valid && (discard == '0) && !redirect_valid;
    assign push_entry = '{instruction: imem_rsp_data, pc: rsp_pc};

    assign out_valid = !fifo_empty && !redirect_valid;
    assign fifo_pop  = out_valid && out_ready;

    fetch_fifo #(
        .entry_t (fetch_entry_t),
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (redirect_valid),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run         <= 1'b0;
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            run         <= 1'b1;
            outstanding <= outstanding_nxt;
            if (redirect_valid) begin
                fetch_pc <= target;
                rsp_pc   <= target;
                // Everything still in flight after this cycle is stale,
                // including a request accepted right now.
                discard  <= outstanding_nxt;
            end else begin
                if (req_hs)    fetch_pc <= fetch_pc + 32'd4;
                if (fifo_push) rsp_pc   <= rsp_pc + 32'd4;
                if (imem_rsp_valid && (discard != '0)) discard <= discard - OW'(1);
            end
        end
    end

    // When empty the pc shown is the next one expected, so the reset view is
    // {NOP, RESET_PC, RESET_PC+4, 0}.
    always_comb begin
        out_pc                = rsp_pc;
        if_id_out.instruction = NOP_INSTRUCTION;
        if (!fifo_empty) begin
            out_pc                = fifo_head.pc;
            if_id_out.instruction = fifo_head.instruction;
        end
        if_id_out.pc        = out_pc;
        if_id_out.pc_plus_4 = out_pc + 32'd4;
        if_id_out.valid     = out_valid;
    end

`ifdef RISCVIBE_FETCH_PERF_EN
    logic        rsp_dropped;
    logic [31:0] flushed;

    assign rsp_dropped = imem_rsp_valid && !fifo_push;
    assign flushed     = redirect_valid ? 32'(fifo_count) : 32'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt   <= '0;
            perf_discard_cnt <= '0;
        end else begin
            perf_fetch_cnt   <= perf_fetch_cnt + 32'(fifo_pop);
            perf_discard_cnt <= perf_discard_cnt + 32'(rsp_dropped) + flushed;
        end
    end
`endif

    // Memory must never answer a request it was not given.
    a_rsp_has_owner: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rsp_valid |-> (outstanding != '0));

    // Credit scheme must make a push into a full FIFO coincide with a pop.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        (fifo_push && fifo_full) |-> fifo_pop);

endmodule

// File: tb/tb_if_prefetch_unit.sv
// -----------------------------------------------------------------------------
// tb_if_prefetch_unit
// Bench for if_prefetch_unit with an in-order instruction memory model of
// configurable latency. Data returned for address A is ~A. Expected deliveries
// go into a scoreboard queue when the memory answers a request of the current
// fetch epoch; pops from the DUT are compared against it.
// -----------------------------------------------------------------------------
module tb_if_prefetch_unit;
    import riscvibe_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        out_ready = 1'b0;
    if_id_reg_t  if_id_out;
`ifdef RISCVIBE_FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_discard_cnt;
`endif

    if_prefetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .out_ready      (out_ready),
`ifdef RISCVIBE_FETCH_PERF_EN
        .perf_fetch_cnt   (perf_fetch_cnt),
        .perf_discard_cnt (perf_discard_cnt),
`endif
        .if_id_out      (if_id_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp;
        int          due;
        int          epoch;
    } mem_t;

    typedef struct {
        logic [31:0] rpc;
        logic [31:0] exp;
    } vec_t;

    mem_t        mq[$];
    logic [31:0] sb[$];

    int checks = 0;
    int failures = 0;
    int cyc, epoch, lat, pops, hs_cnt;
    int first_valid_cyc, first_pop_cyc, last_pop_cyc;
    logic [31:0] exp_fetch, last_pop_pc, last_req_addr;
    bit  last_req_valid, last_hs, last_rsp, last_valid;
    bit  stall, rand_rdy, rand_ordy, redir;
    logic [31:0] redir_pc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b0;
        redirect_valid = 1'b0;
        out_ready = 1'b0;
        mq.delete();
        sb.delete();
        @(negedge clk);
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_req_addr", imem_req_addr, 32'h0);
        chk("rst_instr", if_id_out.instruction, NOP_INSTRUCTION);
        chk("rst_pc", if_id_out.pc, 32'h0);
        chk("rst_pc_plus_4", if_id_out.pc_plus_4, 32'h4);
        chk("rst_valid", 32'(if_id_out.valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;       // release cycle is cycle 0
        cyc = 1; epoch = 0; pops = 0; hs_cnt = 0;
        first_valid_cyc = -1; first_pop_cyc = -1; last_pop_cyc = -1;
        exp_fetch = 32'h0;
        stall = 0; rand_rdy = 0; rand_ordy = 0; redir = 0; redir_pc = '0;
    endtask

    // One clock cycle: drive inputs at negedge, sample #1 later, update models.
    task automatic cycle();
        mem_t        r;
        logic [31:0] e;
        bit          hs, pop;
        @(negedge clk);
        if (mq.size() != 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = ~mq[0].addr;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
        imem_req_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        out_ready      = rand_ordy ? ($urandom_range(0, 3) != 0) : !stall;
        redirect_valid = redir;
        redirect_pc    = redir_pc;
        #1;
        hs  = imem_req_valid && imem_req_ready;
        pop = if_id_out.valid && out_ready;
        last_req_valid = imem_req_valid;
        last_req_addr  = imem_req_addr;
        last_hs    = hs;
        last_rsp   = imem_rsp_valid;
        last_valid = if_id_out.valid;
        if (if_id_out.valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (redir) chk("valid_in_redirect_cycle", 32'(if_id_out.valid), 32'd0);
        if (pop) begin
            if (sb.size() == 0) begin
                chk("unexpected_pop_pc", if_id_out.pc, 32'hxxxx_xxxx);
            end else begin
                e = sb.pop_front();
                chk("pop_pc", if_id_out.pc, e);
                chk("pop_instr", if_id_out.instruction, ~e);
                chk("pop_pc_plus_4", if_id_out.pc_plus_4, e + 32'd4);
            end
            pops++;
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
            last_pop_cyc = cyc;
            last_pop_pc  = if_id_out.pc;
        end
        if (imem_rsp_valid) begin
            r = mq.pop_front();
            if (r.epoch == epoch && !redir) sb.push_back(r.exp);
        end
        if (hs) begin
            chk("req_addr", imem_req_addr, exp_fetch);
            mq.push_back('{addr: imem_req_addr, exp: exp_fetch, due: cyc + lat, epoch: epoch});
            exp_fetch = exp_fetch + 32'd4;
            hs_cnt++;
        end
        if (redir) begin
            epoch++;
            sb.delete();
            exp_fetch = redir_pc & 32'hFFFF_FFFC;
        end
        cyc++;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic run_until_pops(input int n, input int budget, input string name);
        int k = 0;
        while (pops < n && k < budget) begin
            cycle();
            k++;
        end
        if (pops < n) begin
            checks++;
            failures++;
            $display("FAIL %s timeout pops=%0d expected=%0d", name, pops, n);
        end
    endtask

    vec_t vecs[5];

    initial begin
        int rcyc, p0;
        vecs[0] = '{rpc: 32'h0000_0103, exp: 32'h0000_0100};
        vecs[1] = '{rpc: 32'h0000_0202, exp: 32'h0000_0200};
        vecs[2] = '{rpc: 32'hFFFF_FFFD, exp: 32'hFFFF_FFFC};
        vecs[3] = '{rpc: 32'h0000_0041, exp: 32'h0000_0040};
        vecs[4] = '{rpc: 32'h0000_1000, exp: 32'h0000_1000};

        // Reset release, 1-cycle memory: first valid at cycle 3, addr 0,4,8.
        lat = 1;
        do_reset();
        run_until_pops(3, 20, "startup");
        chk("first_valid_cycle", 32'(first_valid_cyc), 32'd3);
        chk("third_pop_pc", last_pop_pc, 32'h8);

        // 16 instructions with no backpressure: no bubbles after fill.
        do_reset();
        run_until_pops(16, 40, "stream16");
        chk("no_bubbles", 32'(last_pop_cyc - first_pop_cyc), 32'd15);
        chk("stream_last_pc", last_pop_pc, 32'h3C);

        // Hazard stall fills the FIFO and throttles requests; release drains.
        do_reset();
        stall = 1;
        run_cycles(12);
        chk("stall_requests", 32'(hs_cnt), 32'd4);
        chk("stall_req_valid", 32'(last_req_valid), 32'd0);
        chk("stall_out_valid", 32'(last_valid), 32'd1);
        chk("stall_pops", 32'(pops), 32'd0);
        stall = 0;
        run_until_pops(4, 10, "drain");
        chk("drain_fourth_pc", last_pop_pc, 32'hC);
        run_cycles(6);

        // Latency 3, two requests in flight, redirect to 0x100.
        lat = 3;
        do_reset();
        for (int i = 0; i < 10 && mq.size() < 2; i++) cycle();
        chk("two_outstanding", 32'(mq.size()), 32'd2);
        redir = 1; redir_pc = 32'h100;
        cycle();
        redir = 0;
        p0 = pops;
        run_until_pops(p0 + 1, 30, "redirect_lat3");
        chk("redirect_lat3_pc", last_pop_pc, 32'h100);
        run_cycles(8);

        // Table: redirects in steady state (response, pop and request all
        // active in the redirect cycle).
        lat = 1;
        do_reset();
        run_cycles(8);
        foreach (vecs[i]) begin
            redir = 1; redir_pc = vecs[i].rpc;
            cycle();
            redir = 0;
            rcyc = cyc - 1;
            chk("redir_cycle_hs", 32'(last_hs), 32'd1);
            chk("redir_cycle_rsp", 32'(last_rsp), 32'd1);
            cycle();
            chk("redir_next_req_valid", 32'(last_req_valid), 32'd1);
            chk("redir_next_req_addr", last_req_addr, vecs[i].exp);
            p0 = pops;
            run_until_pops(p0 + 1, 20, "redir_vec");
            chk("redir_first_pc", last_pop_pc, vecs[i].exp);
            chk("redir_latency", 32'(last_pop_cyc - rcyc), 32'd3);
            run_cycles(6);
        end

        // Random backpressure on both sides, occasional redirects.
        lat = 2;
        do_reset();
        rand_rdy = 1; rand_ordy = 1;
        for (int i = 0; i < 300; i++) begin
            redir = ($urandom_range(0, 24) == 0);
            redir_pc = $urandom;
            cycle();
        end
        redir = 0; rand_rdy = 0; rand_ordy = 0;
        p0 = pops;
        run_until_pops(p0 + 4, 30, "random_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout time=%0t", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/if_prefetch_unit.md
# if_prefetch_unit

Decoupled instruction-fetch front end for the RISC-Vibe 5-stage pipeline, replacing the combinational-memory fetch path. Issues word fetches to a variable-latency instruction memory over a valid/ready request and response interface. Buffers returned instructions in a parametrised prefetch FIFO. Presents one `if_id_reg_t` per cycle to the IF/ID register; an EX-stage redirect discards in-flight and buffered fetches.

## Interface
- `FIFO_DEPTH`, 4: prefetch entries; power of 2, ≥2.
- `MAX_OUTSTANDING`, 2: maximum accepted-but-unanswered memory requests; 1..FIFO_DEPTH.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset; word aligned.

- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous, active-low reset
- `redirect_valid`  in  1  taken branch/jump from EX; kill everything younger
- `redirect_pc`  in  32  new fetch address; bits [1:0] ignored
- `imem_req_valid`  out  1  fetch request
- `imem_req_ready`  in  1  memory accepts request
- `imem_req_addr`  out  32  word-aligned byte address
- `imem_rsp_valid`  in  1  instruction returned; in request order; always accepted
- `imem_rsp_data`  in  32  instruction word
- `out_ready`  in  1  IF/ID can accept (low = hazard stall)
- `if_id_out`  out  `if_id_reg_t`  instruction, pc, pc_plus_4, valid
- `perf_fetch_cnt`  out  32  present only with the perf macro
- `perf_discard_cnt`  out  32  present only with the perf macro

## Operation
- State: `fetch_pc`, `rsp_pc` (pc of next accepted response), `outstanding` counter, `discard` counter, and a FIFO of {instruction, pc}.
- Request: `imem_req_valid = (outstanding < MAX_OUTSTANDING) && (outstanding + fifo_count < FIFO_DEPTH)`; `imem_req_addr = fetch_pc`. On handshake: `fetch_pc += 4` (wraps mod 2^32), outstanding +1.
- Response: outstanding −1. If `discard > 0`, drop the response and decrement `discard`; otherwise push {data, rsp_pc} and set `rsp_pc += 4`.
- Output: `if_id_out` is the FIFO head. `pc_plus_4 = pc + 4`. `valid = !empty && !redirect_valid`. Pop on `valid && out_ready`. When empty, `instruction` = NOP 32'h0000_0013.
- Redirect: takes priority over push and pop. Effects:
  - FIFO cleared.
  - `fetch_pc` and `rsp_pc` set to `{redirect_pc[31:2], 2'b00}`.
  - `discard` set to the post-cycle outstanding count, which includes a request accepted this cycle and excludes a response arriving this cycle.
  - A response arriving in the redirect cycle is dropped.
- Simultaneous push and pop with a full FIFO is legal; the credit check guarantees no overflow. Any response received with `outstanding == 0` is a protocol error and is covered by an assertion.

## Timing
- Reset values:
  - `imem_req_valid` 0 while `rst_n` low; `imem_req_addr` = RESET_PC.
  - `if_id_out` = {NOP, RESET_PC, RESET_PC+4, valid 0}.
  - All counters 0; FIFO empty.
- Reset mid-operation drops all state; responses to pre-reset requests must not arrive (memory is reset by the same `rst_n`).
- `imem_req_valid` may assert in the first cycle after reset release.
- Response-to-output latency is 1 cycle: the push is registered, with no bypass.
- Redirect at cycle N: `imem_req_addr` = new pc at N+1. With 1-cycle memory latency, `if_id_out.valid` rises at N+3.
- Steady state: 1 instruction per cycle when memory has 1-cycle latency and `MAX_OUTSTANDING ≥ 2`.

## Configuration
- `RISCVIBE_FETCH_PERF_EN` defined:
  - `perf_fetch_cnt` increments on each pop.
  - `perf_discard_cnt` increments by the number of dropped responses plus flushed FIFO entries each cycle.
  - Both reset to 0 and wrap at 2^32.
- Undefined: both ports and all counter logic are absent.

## Structure
- `riscvibe_pkg` holds:
  - `if_id_reg_t` (existing);
  - `NOP_INSTRUCTION` (moved from local);
  - a new `fetch_entry_t` {instruction, pc}.
- Sub-module `fetch_fifo`: a synchronous FIFO parametrised on entry type and depth, with push, pop, clear, count, full and empty. Clear has priority over push and pop.

## Test plan
- Reset release with memory always ready and 1-cycle latency → first request addr 0x0, then 0x4, 0x8. `if_id_out.valid` first high at cycle 3 with pc 0x0, pc_plus_4 0x4.
- Zero backpressure over 16 instructions → 16 consecutive pops with pc 0x0..0x3C and no bubbles after fill.
- `out_ready` held 0 → FIFO fills to 4 entries and `imem_req_valid` drops. Release → 4 entries drain in order with none lost or duplicated.
- With 2 outstanding requests (memory latency 3), redirect to 0x100 → both stale responses are dropped. The next valid output has pc 0x100; perf discard counter +2 plus flushed entries.
- `redirect_pc` 0x103 → `imem_req_addr` 0x100, delivered pc 0x100.
- Redirect in the same cycle as a response, a pop and a request handshake → the response is dropped and `valid` is 0 that cycle. `discard` = 1 for the accepted request, and the output resumes at the redirect target.
